// File: rtl/irq_capture.sv
// Request capture stage: edge-sticky pending register, masked pending vector
// and a valid/ready presenter of the highest-priority pending line.
// Optional macro IRQ_LEVEL_MODE_EN switches pending to level-sampled capture.
module irq_capture #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     pend_out,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ready,
  output logic [N-1:0]     ovf,
  input  logic             ovf_clr
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [N-1:0]     r_pend;
  logic [N-1:0]     w_pend_nxt;
  logic [N-1:0]     r_ovf;
  logic [N-1:0]     w_ovf_nxt;
  logic [N-1:0]     w_avail;
  logic [IDX_W-1:0] w_cand;
  logic             w_cand_vld;

`ifdef IRQ_LEVEL_MODE_EN
  // Level mode: pending mirrors the request lines; the source owns clearing.
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ovf_clr;

  always_comb begin
    w_pend_nxt = req_in;
    w_ovf_nxt  = '0;
  end
`else
  logic [N-1:0] r_req_d;
  logic [N-1:0] w_edge;
  logic [N-1:0] w_clr;
  logic         w_hs;

  assign w_hs   = (r_state == PRESENT) && irq_ready;
  assign w_edge = req_in & ~r_req_d;

  always_comb begin
    w_clr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_clr[i] = w_hs && (r_idx == IDX_W'(i));
    end
  end

  // A new edge overrides a same-cycle clear so the request is never lost.
  always_comb begin
    w_pend_nxt = (r_pend & ~w_clr) | w_edge;
    w_ovf_nxt  = (ovf_clr ? '0 : r_ovf) | (w_edge & r_pend & ~w_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d <= '0;
    end else begin
      r_req_d <= req_in;
    end
  end
`endif

  assign w_avail = r_pend & ~mask;

  always_comb begin
    w_cand     = '0;
    w_cand_vld = |w_avail;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_avail[i]) begin
        w_cand = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_cand_vld) begin
          w_state_nxt = PRESENT;
          w_idx_nxt   = w_cand;
        end
      end
      PRESENT: begin
        if (irq_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pend  <= '0;
      r_ovf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign pend_out  = w_avail;
  assign irq_valid = (r_state == PRESENT);
  assign irq_idx   = r_idx;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_irq_capture.sv
// Self-checking bench for irq_capture: directed scenarios plus randomized
// traffic against a behavioural model of the capture/present rules.
module tb_irq_capture;
  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_in;
  logic [N-1:0]     mask;
  logic [N-1:0]     pend_out;
  logic             irq_valid;
  logic [IDX_W-1:0] irq_idx;
  logic             irq_ready;
  logic [N-1:0]     ovf;
  logic             ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0]     m_pend;
  logic [N-1:0]     m_reqd;
  logic [N-1:0]     m_ovf;
  logic             m_valid;
  logic [IDX_W-1:0] m_idx;

  always #5 clk = ~clk;

  irq_capture #(.N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .pend_out(pend_out),
    .irq_valid(irq_valid), .irq_idx(irq_idx), .irq_ready(irq_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // Model of one clock edge, from the rules: rising request -> pending,
  // serviced index -> cleared, re-rise while pending -> overrun,
  // idle presenter picks the highest unmasked pending line.
  function automatic void model_step();
    logic [N-1:0] np;
    logic [N-1:0] no;
    logic hs;
    int top;
    if (rst) begin
      m_pend = '0; m_reqd = '0; m_ovf = '0; m_valid = 1'b0; m_idx = '0;
      return;
    end
    hs = m_valid && irq_ready;
`ifdef IRQ_LEVEL_MODE_EN
    np = req_in;
    no = '0;
`else
    np = m_pend;
    no = ovf_clr ? '0 : m_ovf;
    for (int i = 0; i < N; i++) begin
      bit rise, done;
      rise = req_in[i] && !m_reqd[i];
      done = hs && (int'(m_idx) == i);
      if (rise && m_pend[i] && !done) no[i] = 1'b1;
      np[i] = rise || (m_pend[i] && !done);
    end
    m_reqd = req_in;
`endif
    if (m_valid) begin
      if (irq_ready) m_valid = 1'b0;
    end else begin
      top = -1;
      for (int i = 0; i < N; i++) if (m_pend[i] && !mask[i]) top = i;
      if (top >= 0) begin
        m_valid = 1'b1;
        m_idx = top[IDX_W-1:0];
      end
    end
    m_pend = np;
    m_ovf  = no;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = '0; mask = '0; irq_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (pend_out !== 4'b0000) begin n_err++; $display("FAIL reset_pend: got %b want 0000", pend_out); end
    n_vec++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", irq_valid); end
    n_vec++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
    n_vec++; if (irq_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", irq_idx); end
    tick();
    n_vec++; if (irq_valid !== 1'b0 || pend_out !== 4'b0000) begin n_err++; $display("FAIL reset_idle: got v=%b p=%b want v=0 p=0000", irq_valid, pend_out); end
  endtask

  task automatic test_single_edge();
    do_reset();
    irq_ready = 1'b1; req_in = 4'b0100;
    tick();
    n_vec++; if (pend_out !== 4'b0100 || irq_valid !== 1'b0) begin n_err++; $display("FAIL single_t1: got p=%b v=%b want p=0100 v=0", pend_out, irq_valid); end
    tick();
    n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd2) begin n_err++; $display("FAIL single_t2: got v=%b idx=%0d want v=1 idx=2", irq_valid, irq_idx); end
    tick();
    n_vec++; if (pend_out !== 4'b0000 || irq_valid !== 1'b0) begin n_err++; $display("FAIL single_t3: got p=%b v=%b want p=0000 v=0", pend_out, irq_valid); end
  endtask

  task automatic test_priority();
    do_reset();
    irq_ready = 1'b1; req_in = 4'b1001;
    tick();
    n_vec++; if (pend_out !== 4'b1001) begin n_err++; $display("FAIL prio_pend1: got %b want 1001", pend_out); end
    tick();
    n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd3) begin n_err++; $display("FAIL prio_first: got v=%b idx=%0d want v=1 idx=3", irq_valid, irq_idx); end
    tick();
    n_vec++; if (pend_out !== 4'b0001 || irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_bubble: got p=%b v=%b want p=0001 v=0", pend_out, irq_valid); end
    tick();
    n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd0) begin n_err++; $display("FAIL prio_second: got v=%b idx=%0d want v=1 idx=0", irq_valid, irq_idx); end
    tick();
    n_vec++; if (pend_out !== 4'b0000 || irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_done: got p=%b v=%b want p=0000 v=0", pend_out, irq_valid); end
  endtask

  task automatic test_hold();
    do_reset();
    req_in = 4'b0010;
    tick(); tick();
    n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd1) begin n_err++; $display("FAIL hold_present: got v=%b idx=%0d want v=1 idx=1", irq_valid, irq_idx); end
    req_in = 4'b1010; mask = 4'b0010;
    tick();
    n_vec++; if (pend_out !== 4'b1000) begin n_err++; $display("FAIL hold_masked_pend: got %b want 1000", pend_out); end
    tick();
    n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd1) begin n_err++; $display("FAIL hold_stable: got v=%b idx=%0d want v=1 idx=1", irq_valid, irq_idx); end
    irq_ready = 1'b1;
    tick();
    n_vec++; if (irq_valid !== 1'b0) begin n_err++; $display("FAIL hold_bubble: got v=%b want 0", irq_valid); end
    tick();
    n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd3) begin n_err++; $display("FAIL hold_next: got v=%b idx=%0d want v=1 idx=3", irq_valid, irq_idx); end
    tick();
    n_vec++; if (pend_out !== 4'b0000 || irq_valid !== 1'b0) begin n_err++; $display("FAIL hold_done: got p=%b v=%b want p=0000 v=0", pend_out, irq_valid); end
  endtask

  task automatic test_overrun();
    do_reset();
    req_in = 4'b0001;
    tick(); tick();
    req_in = 4'b0000;
    tick();
    req_in = 4'b0001;
    tick();
    n_vec++; if (ovf !== 4'b0001) begin n_err++; $display("FAIL ovr_set: got %b want 0001", ovf); end
    n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd0) begin n_err++; $display("FAIL ovr_present: got v=%b idx=%0d want v=1 idx=0", irq_valid, irq_idx); end
    req_in = 4'b0000;
    tick();
    req_in = 4'b0001; irq_ready = 1'b1;
    tick();
    n_vec++; if (pend_out !== 4'b0001 || irq_valid !== 1'b0) begin n_err++; $display("FAIL ovr_setwins: got p=%b v=%b want p=0001 v=0", pend_out, irq_valid); end
    n_vec++; if (ovf !== 4'b0001) begin n_err++; $display("FAIL ovr_unchanged: got %b want 0001", ovf); end
    req_in = 4'b0000; irq_ready = 1'b0; ovf_clr = 1'b1;
    tick();
    n_vec++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL ovr_clr: got %b want 0000", ovf); end
    req_in = 4'b0001;
    tick();
    n_vec++; if (ovf !== 4'b0001) begin n_err++; $display("FAIL ovr_beats_clr: got %b want 0001", ovf); end
    tick();
    n_vec++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL ovr_clr2: got %b want 0000", ovf); end
    ovf_clr = 1'b0;
  endtask

`ifdef IRQ_LEVEL_MODE_EN
  task automatic test_level();
    do_reset();
    req_in = 4'b0010; irq_ready = 1'b1;
    tick();
    n_vec++; if (pend_out !== 4'b0010) begin n_err++; $display("FAIL lvl_pend: got %b want 0010", pend_out); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (irq_valid !== 1'b1 || irq_idx !== 2'd1) begin n_err++; $display("FAIL lvl_present%0d: got v=%b idx=%0d want v=1 idx=1", k, irq_valid, irq_idx); end
      tick();
      n_vec++; if (irq_valid !== 1'b0 || pend_out !== 4'b0010) begin n_err++; $display("FAIL lvl_bubble%0d: got v=%b p=%b want v=0 p=0010", k, irq_valid, pend_out); end
    end
    tick();
    req_in = 4'b0000;
    tick();
    n_vec++; if (pend_out !== 4'b0000 || irq_valid !== 1'b0) begin n_err++; $display("FAIL lvl_drop: got p=%b v=%b want p=0000 v=0", pend_out, irq_valid); end
    tick();
    n_vec++; if (irq_valid !== 1'b0 || ovf !== 4'b0000) begin n_err++; $display("FAIL lvl_quiet: got v=%b ovf=%b want v=0 ovf=0000", irq_valid, ovf); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_in    = N'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      irq_ready = $urandom_range(0, 1) == 1;
      ovf_clr   = ($urandom_range(0, 7) == 0);
      tick();
      n_vec++; if (pend_out !== (m_pend & ~mask)) begin n_err++; $display("FAIL rnd_pend c=%0d: got %b want %b", c, pend_out, m_pend & ~mask); end
      n_vec++; if (irq_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, irq_valid, m_valid); end
      n_vec++; if (irq_idx !== m_idx) begin n_err++; $display("FAIL rnd_idx c=%0d: got %0d want %0d", c, irq_idx, m_idx); end
      n_vec++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, ovf, m_ovf); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef IRQ_LEVEL_MODE_EN
    test_level();
`else
    test_single_edge();
    test_priority();
    test_hold();
    test_overrun();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
